// File: rtl/signal_conditioner.sv
// Purpose: synchronise a pad input, glitch-filter it, count rejected pulses, emit prescaled rising-edge pulses.
// Latency: Le+2 clk edges from the first edge sampling a new stable value to level; edge_out coincides with level rising.
// Backpressure: none, free-running; optional prescaler is enabled by defining SIGNAL_CONDITIONER_PRESCALE_EN.
module signal_conditioner (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal,
    input  logic       cfg_load,
    input  logic [3:0] filter_len,
    input  logic [3:0] prescale,
    output logic       level,
    output logic       edge_out,
    output logic [7:0] glitch_count
);

    logic       sync_d;
    logic       sync_q;
    logic [3:0] l_reg;
    logic [3:0] cnt;
    logic [3:0] le;
    logic [3:0] cnt_inc;

`ifdef SIGNAL_CONDITIONER_PRESCALE_EN
    logic [3:0] p_reg;
    logic [3:0] pre_cnt;
`else
    logic       prescale_unused;
    assign prescale_unused = ^prescale;
`endif

    // A programmed length of zero filters like a length of one.
    assign le      = (l_reg == 4'd0) ? 4'd1 : l_reg;
    assign cnt_inc = cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_d       <= 1'b0;
            sync_q       <= 1'b0;
            level        <= 1'b0;
            cnt          <= 4'd0;
            edge_out     <= 1'b0;
            glitch_count <= 8'd0;
            l_reg        <= 4'd2;
`ifdef SIGNAL_CONDITIONER_PRESCALE_EN
            p_reg        <= 4'd0;
            pre_cnt      <= 4'd0;
`endif
        end else begin
            sync_d   <= signal;
            sync_q   <= sync_d;
            edge_out <= 1'b0;
            // Config load wins over a transition that would qualify this cycle.
            if (cfg_load) begin
                l_reg        <= filter_len;
                cnt          <= 4'd0;
                glitch_count <= 8'd0;
`ifdef SIGNAL_CONDITIONER_PRESCALE_EN
                p_reg        <= prescale;
                pre_cnt      <= 4'd0;
`endif
            end else if (sync_q != level) begin
                if (cnt_inc == le) begin
                    level <= sync_q;
                    cnt   <= 4'd0;
                    if (sync_q) begin
`ifdef SIGNAL_CONDITIONER_PRESCALE_EN
                        if (pre_cnt == p_reg) begin
                            edge_out <= 1'b1;
                            pre_cnt  <= 4'd0;
                        end else begin
                            pre_cnt  <= pre_cnt + 4'd1;
                        end
`else
                        edge_out <= 1'b1;
`endif
                    end
                end else begin
                    cnt <= cnt_inc;
                end
            end else begin
                // Input fell back before the filter qualified it.
                if ((cnt != 4'd0) && (glitch_count != 8'hFF))
                    glitch_count <= glitch_count + 8'd1;
                cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_signal_conditioner.sv
// Self-checking bench for signal_conditioner: directed vector table, corner sequences, randomized run vs reference model.
module tb_signal_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       signal;
    logic       cfg_load;
    logic [3:0] filter_len;
    logic [3:0] prescale;
    logic       level;
    logic       edge_out;
    logic [7:0] glitch_count;

    signal_conditioner dut (
        .clk          (clk),
        .reset        (reset),
        .signal       (signal),
        .cfg_load     (cfg_load),
        .filter_len   (filter_len),
        .prescale     (prescale),
        .level        (level),
        .edge_out     (edge_out),
        .glitch_count (glitch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: run-length view of the synchronised input.
    int m_s1, m_s2, m_level, m_run, m_glitch, m_L, m_P, m_rises, m_edge;

    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] fl;
        logic [3:0] ps;
        logic       sig;
        logic       exp_level;
        logic       exp_edge;
        logic [7:0] exp_glitch;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int rst, input int load, input int fl, input int ps, input int sig,
                       input int lv, input int ed, input int gl);
        vec_t v;
        v.rst = rst[0]; v.load = load[0]; v.fl = fl[3:0]; v.ps = ps[3:0]; v.sig = sig[0];
        v.exp_level = lv[0]; v.exp_edge = ed[0]; v.exp_glitch = gl[7:0];
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        int le;
        int pe;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_glitch = 0;
            m_L = 2; m_P = 0; m_rises = 0; m_edge = 0;
        end else begin
            m_edge = 0;
            if (cfg_load) begin
                m_L = int'(filter_len); m_P = int'(prescale);
                m_run = 0; m_rises = 0; m_glitch = 0;
            end else begin
                le = (m_L < 1) ? 1 : m_L;
                if (m_s2 != m_level) begin
                    m_run++;
                    if (m_run >= le) begin
                        m_level = m_s2;
                        m_run = 0;
                        if (m_level == 1) begin
                            m_rises++;
`ifdef SIGNAL_CONDITIONER_PRESCALE_EN
                            pe = m_P;
`else
                            pe = 0;
`endif
                            m_edge = ((m_rises % (pe + 1)) == 0) ? 1 : 0;
                        end
                    end
                end else begin
                    if (m_run > 0 && m_glitch < 255) m_glitch++;
                    m_run = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = int'(signal);
        end
    endtask

    task automatic drive(input int r, input int l, input int fl, input int ps, input int s);
        reset = r[0]; cfg_load = l[0]; filter_len = fl[3:0]; prescale = ps[3:0]; signal = s[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int bad;
        int edges;
        int rises;
        int mask;
        int prev_lv;
        int run_left;
        int sig_r;
        int exp_edges;
        int exp_mask;

        drive(1, 0, 0, 0, 0);

        // Directed table: default filter, reset mid-filter, fall, cfg_load racing a rise.
        add(1,0,0,0,0, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 1,1,0);
        add(0,0,0,0,1, 1,0,0);
        add(0,0,0,0,1, 1,0,0);
        add(0,0,0,0,0, 1,0,0);
        add(0,0,0,0,0, 1,0,0);
        add(0,0,0,0,0, 1,0,0);
        add(0,0,0,0,0, 0,0,0);
        add(0,0,0,0,0, 0,0,0);
        add(0,1,4,0,0, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(1,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 1,1,0);
        add(0,0,0,0,0, 1,0,0);
        add(0,0,0,0,0, 1,0,0);
        add(0,0,0,0,0, 1,0,0);
        add(0,0,0,0,0, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,1,3,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,1, 1,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(int'(tbl[i].rst), int'(tbl[i].load), int'(tbl[i].fl), int'(tbl[i].ps), int'(tbl[i].sig));
            tick();
            check($sformatf("vec%0d_level", i), int'(level), int'(tbl[i].exp_level));
            check($sformatf("vec%0d_edge", i), int'(edge_out), int'(tbl[i].exp_edge));
            check($sformatf("vec%0d_glitch", i), int'(glitch_count), int'(tbl[i].exp_glitch));
        end

        // L=3, three 2-cycle high pulses: all rejected.
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 3, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        bad = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 8; c++) begin
                signal = (c < 2);
                tick();
                if (level !== 1'b0 || edge_out !== 1'b0) bad++;
            end
        end
        check("short_pulses_level_or_edge", bad, 0);
        check("short_pulses_glitch_count", int'(glitch_count), 3);

        // Prescaler: 8 clean 20-cycle pulses.
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 2, 3, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        edges = 0; rises = 0; mask = 0; prev_lv = int'(level); bad = 0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 20; c++) begin
                signal = (c < 10);
                tick();
                if (level === 1'b1 && prev_lv == 0) rises++;
                if (edge_out === 1'b1) begin
                    edges++;
                    if (level === 1'b1 && prev_lv == 0) mask |= (1 << (rises - 1));
                    else bad++;
                end
                prev_lv = int'(level);
            end
        end
`ifdef SIGNAL_CONDITIONER_PRESCALE_EN
        exp_edges = 2; exp_mask = 8'h88;
`else
        exp_edges = 8; exp_mask = 8'hFF;
`endif
        check("prescale_rises", rises, 8);
        check("prescale_edge_count", edges, exp_edges);
        check("prescale_edge_positions", mask, exp_mask);
        check("prescale_edge_off_rise", bad, 0);

        // Glitch counter saturation at L=5 with level held high, then cleared by cfg_load.
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 5, 0, 1); tick();
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) tick();
        check("sat_level_high", int'(level), 1);
        for (int g = 0; g < 300; g++) begin
            for (int c = 0; c < 4; c++) begin
                signal = (c != 0);
                tick();
            end
            if (g == 253) check("sat_count_254", int'(glitch_count), 254);
            if (g == 254) check("sat_count_255", int'(glitch_count), 255);
        end
        check("sat_count_held", int'(glitch_count), 255);
        check("sat_level_kept", int'(level), 1);
        drive(0, 1, 5, 0, 1); tick();
        check("sat_cleared", int'(glitch_count), 0);
        check("sat_load_level", int'(level), 1);
        drive(0, 0, 0, 0, 1); tick();
        check("sat_after_load_level", int'(level), 1);

        // Randomized run against the reference model.
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        run_left = 0; sig_r = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (run_left == 0) begin
                sig_r = 1 - sig_r;
                run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(1, 6);
            end
            run_left--;
            signal = sig_r[0];
            reset = ($urandom_range(0, 999) == 0);
            cfg_load = ($urandom_range(0, 79) == 0);
            filter_len = 4'($urandom_range(0, 15));
            prescale = 4'($urandom_range(0, 15));
            tick();
            if (level !== m_level[0] || edge_out !== m_edge[0] || glitch_count !== m_glitch[7:0]) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_cycle%0d: got level=%0d edge=%0d glitch=%0d, expected level=%0d edge=%0d glitch=%0d",
                         cyc, level, edge_out, glitch_count, m_level, m_edge, m_glitch);
            end else begin
                n_checks++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
